// File: rtl/cordic_sched_pkg.sv
// Shared sizing, formats and helpers for the CORDIC NCO scheduler.
// Channel count and widths are fixed here; the top and rr_pick size off them.
package cordic_sched_pkg;

  localparam int N_CH       = 4;
  localparam int CH_W       = 2;
  localparam int PHASE_W    = 32;
  localparam int WIDTH      = 24;
  localparam int CORDIC_LAT = 1;

  // Q1.22 radians: one integer bit, 22 fraction bits, inside a WIDTH-bit word
  localparam int Q_INT  = 1;
  localparam int Q_FRAC = 22;
  localparam logic [WIDTH-1:0] HALF_PI_Q22 = 24'h6487ED;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic [1:0]      q;
  } tag_t;

  // Map the within-quadrant fraction of a turn onto [0, pi/2) in Q1.22.
  function automatic logic [WIDTH-1:0] fold_phase(input logic [PHASE_W-1:0] acc);
    logic [Q_FRAC-1:0]       f;
    logic [Q_FRAC+WIDTH-1:0] prod;
    f    = acc[PHASE_W-3 -: Q_FRAC];
    prod = {{WIDTH{1'b0}}, f} * {{Q_FRAC{1'b0}}, HALF_PI_Q22};
    return prod[Q_FRAC +: WIDTH];
  endfunction

  // Rotate a first-quadrant {sin, cos} pair back into quadrant q.
  function automatic logic [2*WIDTH-1:0] restore_quadrant(input logic [1:0]       q,
                                                          input logic [WIDTH-1:0] s,
                                                          input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] ns;
    logic [WIDTH-1:0] nc;
    ns = -s;
    nc = -c;
    case (q)
      2'd0:    return {s, c};
      2'd1:    return {c, ns};
      2'd2:    return {ns, nc};
      default: return {nc, s};
    endcase
  endfunction

endpackage

// File: rtl/cordic_nco_scheduler_rr_pick.sv
// Round-robin first-set finder: lowest pending channel at or after rr_ptr, wrapping.
module rr_pick
  import cordic_sched_pkg::*;
#(
  parameter int N = N_CH,
  parameter int W = CH_W
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] grant,
  output logic         found
);

  // scan offsets 0..N-1 from rr_ptr and keep the first hit
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && pending[W'(idx)]) begin
        found = 1'b1;
        grant = W'(idx);
      end
    end
  end

endmodule

// File: rtl/cordic_nco_scheduler.sv
// Time-shares one external CORDIC rotator across N_CH NCO channels.
// Each sample_tick issues one folded phase per enabled channel, round-robin;
// results come back tagged and are rotated into their original quadrant.
//
// state | meaning
// IDLE  | no batch; waiting for a tick with a nonzero ch_en
// ISSUE | one pending channel granted per cycle
// DRAIN | all issued; waiting for in-flight results to leave the tag pipe
module cordic_nco_scheduler
  import cordic_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic [N_CH-1:0]    ch_en,
  input  logic               cfg_we,
  input  logic               cfg_clr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_fcw,
  output logic [WIDTH-1:0]   cordic_phase,
  input  logic [WIDTH-1:0]   cordic_sin,
  input  logic [WIDTH-1:0]   cordic_cos,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [WIDTH-1:0]   out_sin,
  output logic [WIDTH-1:0]   out_cos,
  output logic               busy,
  output logic               overrun
);

  sched_state_t       state;
  sched_state_t       state_nx;
  logic [N_CH-1:0]    pending;
  logic [N_CH-1:0]    grant_oh;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant;
  logic               found;
  logic               issue;
  logic               tick_accept;
  logic               pipe_empty;
  logic               cfg_hit;
  logic [PHASE_W-1:0] acc [N_CH];
  logic [PHASE_W-1:0] fcw [N_CH];
  logic [PHASE_W-1:0] acc_g;
  tag_t               tag_pipe [CORDIC_LAT+1];

  rr_pick #(
    .N (N_CH),
    .W (CH_W)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .found   (found)
  );

  assign acc_g = acc[grant];

  // a tick only starts a batch when nothing is left to issue
  always_comb begin
    tick_accept = sample_tick && (pending == '0) && (ch_en != '0);
    cfg_hit     = cfg_we && (int'(cfg_ch) < N_CH);
    grant_oh    = '0;
    grant_oh[grant] = found;
  end

  // in-flight detection over every tag stage
  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 0; k <= CORDIC_LAT; k++) begin
      if (tag_pipe[k].valid) pipe_empty = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick_accept) state_nx = ISSUE;
      ISSUE:   if ((pending & ~grant_oh) == '0) state_nx = DRAIN;
      DRAIN: begin
        if (tick_accept)     state_nx = ISSUE;
        else if (pipe_empty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = (state != IDLE);
    issue = (state == ISSUE) && found;
  end

  // pending set, round-robin pointer and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (tick_accept)  pending <= ch_en;
      else if (issue)   pending <= pending & ~grant_oh;
      if (issue)        rr_ptr  <= (grant == CH_W'(N_CH-1)) ? '0 : grant + 1'b1;
      if (sample_tick && (pending != '0)) overrun <= 1'b1;
    end
  end

  // per-channel FCW and accumulator; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        fcw[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_hit && (cfg_ch == CH_W'(i))) fcw[i] <= cfg_fcw;
        if (cfg_hit && cfg_clr && (cfg_ch == CH_W'(i)))
          acc[i] <= '0;
        else if (issue && (grant == CH_W'(i)))
          acc[i] <= acc[i] + fcw[i];
      end
    end
  end

  // folded phase to the rotator plus its tag, aligned to the rotator latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cordic_phase <= '0;
      for (int k = 0; k <= CORDIC_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (issue) cordic_phase <= fold_phase(acc_g);
      tag_pipe[0] <= {issue, grant, acc_g[PHASE_W-1 -: 2]};
      for (int k = 1; k <= CORDIC_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // quadrant restore and tagged output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sin   <= '0;
      out_cos   <= '0;
    end else begin
      out_valid <= tag_pipe[CORDIC_LAT].valid;
      if (tag_pipe[CORDIC_LAT].valid) begin
        out_ch             <= tag_pipe[CORDIC_LAT].ch;
        {out_sin, out_cos} <= restore_quadrant(tag_pipe[CORDIC_LAT].q, cordic_sin, cordic_cos);
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco_scheduler.sv
// Bench for cordic_nco_scheduler with a linear one-cycle rotator stand-in:
// sin = phase, cos = A - phase, so every expected word is easy to derive by hand.
module tb_cordic_nco_scheduler;
  import cordic_sched_pkg::*;

  localparam logic [23:0] A  = 24'h700000;
  localparam logic [23:0] NA = 24'h900000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [3:0]  ch_en = '0;
  logic        cfg_we = 1'b0;
  logic        cfg_clr = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_fcw = '0;
  logic [23:0] cordic_phase;
  logic [23:0] cordic_sin = '0;
  logic [23:0] cordic_cos = '0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [23:0] out_sin;
  logic [23:0] out_cos;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  ch;
    logic [23:0] ph;
    logic [23:0] s;
    logic [23:0] c;
  } vec_t;

  vec_t vt [9];

  cordic_nco_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .ch_en        (ch_en),
    .cfg_we       (cfg_we),
    .cfg_clr      (cfg_clr),
    .cfg_ch       (cfg_ch),
    .cfg_fcw      (cfg_fcw),
    .cordic_phase (cordic_phase),
    .cordic_sin   (cordic_sin),
    .cordic_cos   (cordic_cos),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_sin      (out_sin),
    .out_cos      (out_cos),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cordic_sin <= cordic_phase;
    cordic_cos <= A - cordic_phase;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [31:0] fcw);
    cfg_we = 1'b1; cfg_clr = 1'b0; cfg_ch = ch; cfg_fcw = fcw;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic resync();
    int w;
    w = 0;
    while (busy && w < 20) begin step(); w++; end
  endtask

  // single-channel tick; optional config write on the grant cycle
  task automatic apply(input vec_t v, input string name, input bit do_cfg, input bit clr,
                       input logic [1:0] cch, input logic [31:0] cfcw);
    int w;
    sample_tick = 1'b1; ch_en = v.en;
    step();
    sample_tick = 1'b0; ch_en = '0;
    if (do_cfg) begin cfg_we = 1'b1; cfg_clr = clr; cfg_ch = cch; cfg_fcw = cfcw; end
    step();
    cfg_we = 1'b0; cfg_clr = 1'b0;
    chk({name, " phase"}, 32'(cordic_phase), 32'(v.ph));
    w = 0;
    while (!out_valid && w < 10) begin step(); w++; end
    chk({name, " latency"}, 32'(w), 32'd2);
    chk({name, " ch"},  32'(out_ch),  32'(v.ch));
    chk({name, " sin"}, 32'(out_sin), 32'(v.s));
    chk({name, " cos"}, 32'(out_cos), 32'(v.c));
    step();
    chk({name, " strobe"}, 32'(out_valid), 32'd0);
    chk({name, " busy"},   32'(busy),      32'd0);
    resync();
  endtask

  // multi-channel tick; chs packs expected channels as {k3,k2,k1,k0}
  task automatic run_batch(input logic [3:0] en, input bit dbl, input int n,
                           input logic [3:0][1:0] chs, input bit vals,
                           input logic [23:0] es, input logic [23:0] ec,
                           input int exp_wait, input string name);
    int w;
    sample_tick = 1'b1; ch_en = en;
    step();
    if (dbl) begin ch_en = 4'b0001; step(); end
    sample_tick = 1'b0; ch_en = '0;
    w = 0;
    while (!out_valid && w < 12) begin step(); w++; end
    chk({name, " latency"}, 32'(w), 32'(exp_wait));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s valid%0d", name, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s ch%0d", name, k),    32'(out_ch),    32'(chs[k]));
      if (vals) begin
        chk($sformatf("%s sin%0d", name, k), 32'(out_sin), 32'(es));
        chk($sformatf("%s cos%0d", name, k), 32'(out_cos), 32'(ec));
      end
      if (k == n - 1) chk({name, " busy at last"}, 32'(busy), 32'd1);
      step();
    end
    chk({name, " count"}, 32'(out_valid), 32'd0);
    chk({name, " busy"},  32'(busy),      32'd0);
    resync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    vt[0] = '{4'b0001, 2'd0, 24'h000000, 24'h000000, A};
    vt[1] = '{4'b0001, 2'd0, 24'h000000, A,          24'h000000};
    vt[2] = '{4'b0001, 2'd0, 24'h000000, 24'h000000, NA};
    vt[3] = '{4'b0001, 2'd0, 24'h000000, NA,         24'h000000};
    vt[4] = '{4'b0100, 2'd2, 24'h000000, 24'h000000, A};
    vt[5] = '{4'b0100, 2'd2, 24'h1921FB, 24'h56DE05, 24'hE6DE05};
    vt[6] = '{4'b0100, 2'd2, 24'h3243F6, 24'hCDBC0A, 24'hC243F6};
    vt[7] = '{4'b0100, 2'd2, 24'h4B65F1, 24'hDB65F1, 24'h4B65F1};
    vt[8] = '{4'b0100, 2'd2, 24'h000000, A,          24'h000000};

    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst out_valid", 32'(out_valid),    32'd0);
    chk("rst busy",      32'(busy),         32'd0);
    chk("rst overrun",   32'(overrun),      32'd0);
    chk("rst phase",     32'(cordic_phase), 32'd0);
    chk("rst out_cos",   32'(out_cos),      32'd0);

    // all four channels from reset: rr order 0..3, all at phase 0
    run_batch(4'b1111, 1'b0, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1, 24'h000000, A, 3, "all4");

    // quarter-turn steps on ch0, then mixed quadrants on ch2
    cfg_write(2'd0, 32'h4000_0000);
    cfg_write(2'd2, 32'h5000_0000);
    for (int i = 0; i < 9; i++) apply(vt[i], $sformatf("vec%0d", i), 1'b0, 1'b0, 2'd0, 32'd0);

    // FCW write on ch2's grant cycle: this issue advances with the old FCW
    apply('{4'b0100, 2'd2, 24'h1921FB, 24'hE6DE05, 24'hA921FB}, "oldfcw0", 1'b1, 1'b0, 2'd2, 32'h1000_0000);
    apply('{4'b0100, 2'd2, 24'h3243F6, 24'hC243F6, 24'h3243F6}, "oldfcw1", 1'b0, 1'b0, 2'd0, 32'd0);

    // rotation continues past the last grant (rr_ptr is 3 here)
    run_batch(4'b0011, 1'b0, 2, {2'd0, 2'd0, 2'd1, 2'd0}, 1'b0, '0, '0, 3, "rot_a");
    run_batch(4'b0101, 1'b0, 2, {2'd0, 2'd0, 2'd0, 2'd2}, 1'b0, '0, '0, 3, "rot_b");

    // second tick one cycle into a batch is dropped and flagged
    chk("overrun pre", 32'(overrun), 32'd0);
    run_batch(4'b0110, 1'b1, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 1'b0, '0, '0, 2, "overrun");
    chk("overrun post", 32'(overrun), 32'd1);
    run_batch(4'b0001, 1'b0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b1, 24'h000000, NA, 3, "after_ovr");

    // clear on ch1's grant cycle wins over the increment
    cfg_write(2'd1, 32'h5000_0000);
    apply('{4'b0010, 2'd1, 24'h000000, 24'h000000, A},          "clr0", 1'b0, 1'b0, 2'd0, 32'd0);
    apply('{4'b0010, 2'd1, 24'h1921FB, 24'h56DE05, 24'hE6DE05}, "clr1", 1'b1, 1'b1, 2'd1, 32'h5000_0000);
    apply('{4'b0010, 2'd1, 24'h000000, 24'h000000, A},          "clr2", 1'b0, 1'b0, 2'd0, 32'd0);

    // reset in the middle of an issue batch
    sample_tick = 1'b1; ch_en = 4'b1111;
    step();
    sample_tick = 1'b0; ch_en = '0;
    step();
    chk("midrst busy pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid),    32'd0);
    chk("midrst out_ch",    32'(out_ch),       32'd0);
    chk("midrst out_sin",   32'(out_sin),      32'd0);
    chk("midrst out_cos",   32'(out_cos),      32'd0);
    chk("midrst phase",     32'(cordic_phase), 32'd0);
    chk("midrst busy",      32'(busy),         32'd0);
    chk("midrst overrun",   32'(overrun),      32'd0);
    step(); step();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) stray++;
    end
    chk("midrst stray valid", 32'(stray), 32'd0);
    run_batch(4'b0001, 1'b0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b1, 24'h000000, A, 3, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
